// File: rtl/pipe_hazard_if.sv
// Bundle of hazard-detection inputs and pipeline control outputs shared between
// the pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       ex_rd;
    logic             ex_memread;
    logic             ex_redirect;
    logic             mem_req;
    logic             mem_ack;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             mem_wb_flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, ex_rd, ex_memread, ex_redirect, mem_req, mem_ack,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
               mem_wb_en, mem_wb_flush, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, ex_rd, ex_memread, ex_redirect, mem_req, mem_ack,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
               mem_wb_en, mem_wb_flush, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32 pipeline with a data-memory timeout FSM.
// Define PIPE_HAZARD_PERF_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_hazard_if.slave hz
);
    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       mem_err_q, mem_err_d;

    logic mem_stall;
    logic mem_abort;
    logic load_use;
    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic ex_mem_en, mem_wb_en, mem_wb_flush;

    // Priority: memory stall, then redirect, then load-use; an abort only adds a WB kill.
    always_comb begin
        mem_stall = (state_q == RUN && hz.mem_req && !hz.mem_ack) ||
                    (state_q == MEM_WAIT && !hz.mem_ack && timer_q < TIMER_LAST);
        mem_abort = (state_q == MEM_WAIT) && !hz.mem_ack && (timer_q >= TIMER_LAST);
        load_use  = hz.ex_memread && (hz.ex_rd != 5'd0) &&
                    ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));

        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        mem_wb_flush = 1'b0;

        if (mem_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (hz.ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end

        if (mem_abort) begin
            mem_wb_flush = 1'b1;
        end

        if (!rst_n) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_en     = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            mem_wb_flush = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        mem_err_d = mem_err_q;
        case (state_q)
            RUN: begin
                timer_d = 8'd0;
                if (hz.mem_req && !hz.mem_ack) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (hz.mem_ack) begin
                    state_d = RUN;
                end else if (mem_abort) begin
                    state_d   = RUN;
                    mem_err_d = 1'b1;
                end else if (timer_q != 8'hFF) begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            timer_q   <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign hz.pc_en        = pc_en;
    assign hz.if_id_en     = if_id_en;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_en     = id_ex_en;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.ex_mem_en    = ex_mem_en;
    assign hz.mem_wb_en    = mem_wb_en;
    assign hz.mem_wb_flush = mem_wb_flush;
    assign hz.mem_err      = mem_err_q && rst_n;

`ifdef PIPE_HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Both counters saturate instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (!mem_stall && hz.ex_redirect && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`else
    assign hz.stall_cnt = '0;
    assign hz.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl (TIMEOUT=4) plus hand-written
// multi-cycle sequences for memory wait, timeout and mid-wait reset.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 16;
`ifdef PIPE_HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Control word order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    // ex_mem_en, mem_wb_en, mem_wb_flush
    localparam logic [7:0] C_NORM  = 8'b11010110;
    localparam logic [7:0] C_REDIR = 8'b11111110;
    localparam logic [7:0] C_LU    = 8'b00011110;
    localparam logic [7:0] C_MSTL  = 8'b00000011;
    localparam logic [7:0] C_ABORT = 8'b11010111;
    localparam logic [7:0] C_RST   = 8'b00000000;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       memread;
        logic       redir;
        logic       req;
        logic       ack;
        logic [7:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   exp_stall;
    int   exp_flush;
    vec_t vecs[10];

    pipe_hazard_if #(.CNT_W(CNT_W)) hz ();

    pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ctrlWord();
        return {hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_en, hz.id_ex_flush,
                hz.ex_mem_en, hz.mem_wb_en, hz.mem_wb_flush};
    endfunction

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic memread,
                                 input logic redir, input logic req, input logic ack);
        @(posedge clk);
        #1;
        hz.id_rs1      = rs1;
        hz.id_rs2      = rs2;
        hz.ex_rd       = rd;
        hz.ex_memread  = memread;
        hz.ex_redirect = redir;
        hz.mem_req     = req;
        hz.mem_ack     = ack;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] exp, input logic exp_err);
        logic [7:0] got;
        got = ctrlWord();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s ctrl got %b want %b", name, got, exp);
        end
        checks++;
        if (hz.mem_err !== exp_err) begin
            errors++;
            $display("[TB] FAIL %s mem_err got %b want %b", name, hz.mem_err, exp_err);
        end
        if (rst_n) begin
            if (!exp[7]) exp_stall++;
            if (exp[5]) exp_flush++;
        end
    endtask

    task automatic checkCounters(input string name);
        logic [CNT_W-1:0] want_s;
        logic [CNT_W-1:0] want_f;
        want_s = PERF ? CNT_W'(exp_stall) : '0;
        want_f = PERF ? CNT_W'(exp_flush) : '0;
        checks++;
        if (hz.stall_cnt !== want_s) begin
            errors++;
            $display("[TB] FAIL %s stall_cnt got %0d want %0d", name, hz.stall_cnt, want_s);
        end
        checks++;
        if (hz.flush_cnt !== want_f) begin
            errors++;
            $display("[TB] FAIL %s flush_cnt got %0d want %0d", name, hz.flush_cnt, want_f);
        end
    endtask

    task automatic stepCheck(input string name, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic memread, input logic redir,
                             input logic req, input logic ack, input logic [7:0] exp,
                             input logic exp_err, input bit do_cnt);
        applyStimulus(rs1, rs2, rd, memread, redir, req, ack);
        @(negedge clk);
        if (do_cnt) checkCounters(name);
        checkOutput(name, exp, exp_err);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_stall = 0;
        exp_flush = 0;

        vecs[0] = '{5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM};
        vecs[1] = '{5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};
        vecs[2] = '{5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};
        vecs[3] = '{5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM};
        vecs[4] = '{5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM};
        vecs[5] = '{5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_REDIR};
        vecs[6] = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, C_REDIR};
        vecs[7] = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, C_NORM};
        vecs[8] = '{5'd9, 5'd8, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, C_LU};
        vecs[9] = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, C_NORM};

        rst_n          = 1'b0;
        hz.id_rs1      = 5'd0;
        hz.id_rs2      = 5'd0;
        hz.ex_rd       = 5'd0;
        hz.ex_memread  = 1'b0;
        hz.ex_redirect = 1'b0;
        hz.mem_req     = 1'b0;
        hz.mem_ack     = 1'b0;

        @(negedge clk);
        checkOutput("reset", C_RST, 1'b0);
        checkCounters("reset");
        #2 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            stepCheck($sformatf("vec%0d", i), vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                      vecs[i].memread, vecs[i].redir, vecs[i].req, vecs[i].ack,
                      vecs[i].exp, 1'b0, i == 0);
        end
        stepCheck("post_table", 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 1'b0, 1'b1);

        $display("[TB] load-use followed by bubble");
        stepCheck("lu_hit", 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LU, 1'b0, 1'b0);
        stepCheck("lu_after", 5'd1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 1'b0, 1'b1);

        $display("[TB] memory wait acked on 4th cycle");
        for (int i = 0; i < 3; i++) begin
            stepCheck($sformatf("mwait%0d", i), 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0,
                      C_MSTL, 1'b0, 1'b0);
        end
        stepCheck("mwait_ack", 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, C_NORM, 1'b0, 1'b0);
        stepCheck("mwait_run", 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 1'b0, 1'b1);

        $display("[TB] memory wait with redirect held");
        for (int i = 0; i < 3; i++) begin
            stepCheck($sformatf("mredir%0d", i), 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0,
                      C_MSTL, 1'b0, 1'b0);
        end
        stepCheck("mredir_ack", 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, C_REDIR, 1'b0, 1'b0);
        stepCheck("mredir_run", 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 1'b0, 1'b1);

        $display("[TB] timeout with TIMEOUT=4");
        for (int i = 0; i < 4; i++) begin
            stepCheck($sformatf("tmo_stall%0d", i), 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0,
                      C_MSTL, 1'b0, 1'b0);
        end
        applyStimulus(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (ctrlWord() !== C_ABORT) begin
            errors++;
            $display("[TB] FAIL tmo_abort ctrl got %b want %b", ctrlWord(), C_ABORT);
        end
        stepCheck("tmo_after", 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 1'b1, 1'b1);
        stepCheck("tmo_sticky", 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, C_REDIR, 1'b1, 1'b0);

        $display("[TB] reset during memory wait");
        stepCheck("rst_wait0", 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, C_MSTL, 1'b1, 1'b0);
        stepCheck("rst_wait1", 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, C_MSTL, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        checkOutput("rst_async", C_RST, 1'b0);
        checkCounters("rst_async");
        @(negedge clk);
        hz.mem_req = 1'b0;
        #2 rst_n = 1'b1;
        stepCheck("rst_resume", 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 1'b0, 1'b1);
        stepCheck("rst_zero_wait", 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, C_NORM, 1'b0, 1'b0);
        stepCheck("rst_final", 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
